reminder_time_setter: RTL and testbench

Consumes the single-cycle Enter/Up/Down pulses produced by the button shaper stage and lets the user edit a reminder time (hour, then minute).
The committed reminder time feeds the reminder comparator and display.
The block is a three-state edit FSM with modulo hour/minute counters, a commit strobe and an inactivity timeout that abandons an unfinished edit.

---
 rtl/reminder_time_setter.sv | 113 +++++++++++
 tb/tb_reminder_time_setter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reminder_time_setter.sv
// reminder_time_setter: edit FSM that sets and commits a reminder time (hour, then minute).
// Ports:
//   Clk, Rst            clock and synchronous active-low reset
//   Enter/Up/Down_pulse one-cycle button events
//   Work_hour/Work_min  value being edited
//   Edit_hour/Edit_min  current edit field
//   Alarm_hour/Alarm_min/Alarm_valid  committed reminder time
//   Commit_pulse        one-cycle strobe on commit
module reminder_time_setter #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Enter_pulse,
    input  logic       Up_pulse,
    input  logic       Down_pulse,
    output logic [4:0] Work_hour,
    output logic [5:0] Work_min,
    output logic       Edit_hour,
    output logic       Edit_min,
    output logic [4:0] Alarm_hour,
    output logic [5:0] Alarm_min,
    output logic       Alarm_valid,
    output logic       Commit_pulse
);
    typedef enum logic [1:0] {S_Idle, S_SetHour, S_SetMin} state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       work_hour_q, work_hour_d, alarm_hour_q, alarm_hour_d;
    logic [5:0]       work_min_q, work_min_d, alarm_min_q, alarm_min_d;
    logic             alarm_valid_q, alarm_valid_d, commit_q, commit_d;
    logic             ev, up, dn, expired;

    // Enter masks Up/Down; Up+Down together changes nothing but still counts as activity
    assign ev      = Enter_pulse | Up_pulse | Down_pulse;
    assign up      = Up_pulse & ~Down_pulse & ~Enter_pulse;
    assign dn      = Down_pulse & ~Up_pulse & ~Enter_pulse;
    assign expired = ~ev && (cnt_q == TERM);

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        work_hour_d   = work_hour_q;
        work_min_d    = work_min_q;
        alarm_hour_d  = alarm_hour_q;
        alarm_min_d   = alarm_min_q;
        alarm_valid_d = alarm_valid_q;
        commit_d      = 1'b0;
        case (state_q)
            S_Idle: if (Enter_pulse) begin
                state_d     = S_SetHour;
                work_hour_d = alarm_hour_q;
                work_min_d  = alarm_min_q;
            end
            S_SetHour: begin
                cnt_d       = ev ? '0 : cnt_q + 1'b1;
                work_hour_d = up ? (work_hour_q == 5'd23 ? 5'd0 : work_hour_q + 5'd1) :
                              dn ? (work_hour_q == 5'd0 ? 5'd23 : work_hour_q - 5'd1) : work_hour_q;
                state_d     = Enter_pulse ? S_SetMin : expired ? S_Idle : S_SetHour;
            end
            S_SetMin: begin
                cnt_d      = ev ? '0 : cnt_q + 1'b1;
                work_min_d = up ? (work_min_q == 6'd59 ? 6'd0 : work_min_q + 6'd1) :
                             dn ? (work_min_q == 6'd0 ? 6'd59 : work_min_q - 6'd1) : work_min_q;
                state_d    = (Enter_pulse || expired) ? S_Idle : S_SetMin;
                if (Enter_pulse) begin
                    alarm_hour_d  = work_hour_q;
                    alarm_min_d   = work_min_q;
                    alarm_valid_d = 1'b1;
                    commit_d      = 1'b1;
                end
            end
            default: state_d = S_Idle;
        endcase
        // leaving an edit state always leaves the counter at zero
        if (state_d == S_Idle) cnt_d = '0;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q       <= S_Idle;
            cnt_q         <= '0;
            work_hour_q   <= '0;
            work_min_q    <= '0;
            alarm_hour_q  <= '0;
            alarm_min_q   <= '0;
            alarm_valid_q <= 1'b0;
            commit_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            work_hour_q   <= work_hour_d;
            work_min_q    <= work_min_d;
            alarm_hour_q  <= alarm_hour_d;
            alarm_min_q   <= alarm_min_d;
            alarm_valid_q <= alarm_valid_d;
            commit_q      <= commit_d;
        end
    end

    assign Work_hour    = work_hour_q;
    assign Work_min     = work_min_q;
    assign Edit_hour    = (state_q == S_SetHour);
    assign Edit_min     = (state_q == S_SetMin);
    assign Alarm_hour   = alarm_hour_q;
    assign Alarm_min    = alarm_min_q;
    assign Alarm_valid  = alarm_valid_q;
    assign Commit_pulse = commit_q;
endmodule

// File: tb/tb_reminder_time_setter.sv
// tb_reminder_time_setter: scoreboard bench for reminder_time_setter with TIMEOUT_CYCLES=8.
module tb_reminder_time_setter;
    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Enter_pulse = 1'b0, Up_pulse = 1'b0, Down_pulse = 1'b0;
    logic [4:0] Work_hour, Alarm_hour;
    logic [5:0] Work_min, Alarm_min;
    logic       Edit_hour, Edit_min, Alarm_valid, Commit_pulse;

    reminder_time_setter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .Enter_pulse(Enter_pulse), .Up_pulse(Up_pulse), .Down_pulse(Down_pulse),
        .Work_hour(Work_hour), .Work_min(Work_min),
        .Edit_hour(Edit_hour), .Edit_min(Edit_min),
        .Alarm_hour(Alarm_hour), .Alarm_min(Alarm_min),
        .Alarm_valid(Alarm_valid), .Commit_pulse(Commit_pulse)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0] wh;
        logic [5:0] wm;
        logic       eh;
        logic       em;
        logic [4:0] ah;
        logic [5:0] am;
        logic       av;
        logic       cp;
    } snap_t;

    typedef struct packed {
        logic [4:0] ah;
        logic [5:0] am;
    } commit_t;

    snap_t   exp_q[$];
    string   name_q[$];
    commit_t com_q[$];
    int      vectors = 0;
    int      miscompares = 0;
    logic    done = 1'b0;

    // monitor: compare every queued snapshot, and every commit strobe against the commit queue
    always @(negedge Clk) begin
        while (exp_q.size() > 0) begin
            snap_t e, a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{Work_hour, Work_min, Edit_hour, Edit_min, Alarm_hour, Alarm_min, Alarm_valid, Commit_pulse};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got wh=%0d wm=%0d eh=%0b em=%0b ah=%0d am=%0d av=%0b cp=%0b, expected wh=%0d wm=%0d eh=%0b em=%0b ah=%0d am=%0d av=%0b cp=%0b",
                         n, a.wh, a.wm, a.eh, a.em, a.ah, a.am, a.av, a.cp,
                         e.wh, e.wm, e.eh, e.em, e.ah, e.am, e.av, e.cp);
            end
        end
        if (Commit_pulse === 1'b1 && !done) begin
            vectors++;
            if (com_q.size() == 0) begin
                miscompares++;
                $display("FAIL commit_unexpected: got strobe ah=%0d am=%0d, expected no strobe", Alarm_hour, Alarm_min);
            end else begin
                commit_t c;
                c = com_q.pop_front();
                if (Alarm_hour !== c.ah || Alarm_min !== c.am) begin
                    miscompares++;
                    $display("FAIL commit_value: got %0d:%0d, expected %0d:%0d", Alarm_hour, Alarm_min, c.ah, c.am);
                end
            end
        end
    end

    task automatic pulse(input logic e, input logic u, input logic d);
        Enter_pulse = e; Up_pulse = u; Down_pulse = d;
        @(posedge Clk); #1;
        Enter_pulse = 0; Up_pulse = 0; Down_pulse = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // st: 0 idle, 1 hour edit, 2 minute edit
    task automatic chk(input string n, input int st, input int wh, input int wm,
                       input int ah, input int am, input logic av, input logic cp);
        exp_q.push_back('{5'(wh), 6'(wm), st == 1, st == 2, 5'(ah), 6'(am), av, cp});
        name_q.push_back(n);
    endtask

    task automatic expect_commit(input int ah, input int am);
        com_q.push_back('{5'(ah), 6'(am)});
    endtask

    initial begin
        // reset
        idle(2);
        chk("reset", 0, 0, 0, 0, 0, 0, 0);
        Rst = 1'b1;
        idle(1);
        chk("post_reset", 0, 0, 0, 0, 0, 0, 0);

        // full entry 7:57
        pulse(1, 0, 0);
        chk("enter_hour", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin idle(2); pulse(0, 1, 0); end
        chk("hour_7", 1, 7, 0, 0, 0, 0, 0);
        idle(2); pulse(1, 0, 0);
        chk("enter_min", 2, 7, 0, 0, 0, 0, 0);
        idle(2); pulse(0, 0, 1);
        chk("min_wrap_59", 2, 7, 59, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin idle(2); pulse(0, 0, 1); end
        chk("min_57", 2, 7, 57, 0, 0, 0, 0);
        idle(2);
        expect_commit(7, 57);
        pulse(1, 0, 0);
        chk("commit_757", 0, 7, 57, 7, 57, 1, 1);
        idle(1);
        chk("commit_drop", 0, 7, 57, 7, 57, 1, 0);

        // drive the committed hour to 23 via 8 Downs from 7
        pulse(1, 0, 0);
        chk("reload", 1, 7, 57, 7, 57, 1, 0);
        for (int i = 0; i < 8; i++) begin idle(1); pulse(0, 0, 1); end
        chk("hour_down_wrap", 1, 23, 57, 7, 57, 1, 0);
        pulse(1, 0, 0);
        expect_commit(23, 57);
        pulse(1, 0, 0);
        chk("commit_2357", 0, 23, 57, 23, 57, 1, 1);

        // hour wrap both ways, minute wrap upward
        idle(1); pulse(1, 0, 0);
        chk("load_23", 1, 23, 57, 23, 57, 1, 0);
        pulse(0, 1, 0);
        chk("hour_up_wrap", 1, 0, 57, 23, 57, 1, 0);
        pulse(0, 0, 1);
        chk("hour_back_23", 1, 23, 57, 23, 57, 1, 0);
        pulse(1, 0, 0);
        for (int i = 0; i < 3; i++) pulse(0, 1, 0);
        chk("min_up_wrap", 2, 23, 0, 23, 57, 1, 0);
        expect_commit(23, 0);
        pulse(1, 0, 0);
        chk("commit_2300", 0, 23, 0, 23, 0, 1, 1);

        // timeout: abandoned exactly 8 cycles after the last Up
        idle(1); pulse(1, 0, 0);
        pulse(0, 1, 0);
        idle(7);
        chk("to_before", 1, 0, 0, 23, 0, 1, 0);
        idle(1);
        chk("to_expired", 0, 0, 0, 23, 0, 1, 0);

        // Up on the terminal-count cycle keeps the edit alive
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        idle(7);
        pulse(0, 1, 0);
        chk("to_rescued", 1, 1, 0, 23, 0, 1, 0);
        idle(7);
        chk("to2_before", 1, 1, 0, 23, 0, 1, 0);
        idle(1);
        chk("to2_expired", 0, 1, 0, 23, 0, 1, 0);

        // Up ignored in idle
        pulse(0, 1, 0);
        chk("idle_up_ignored", 0, 1, 0, 23, 0, 1, 0);

        // priority: Enter beats Up; Up+Down together is a no-op
        pulse(1, 0, 0);
        pulse(1, 1, 0);
        chk("enter_priority", 2, 23, 0, 23, 0, 1, 0);
        pulse(0, 1, 1);
        chk("up_down_noop", 2, 23, 0, 23, 0, 1, 0);

        // reset mid-edit discards everything
        Rst = 1'b0;
        idle(1);
        Rst = 1'b1;
        chk("reset_mid_edit", 0, 0, 0, 0, 0, 0, 0);
        pulse(1, 0, 0);
        chk("after_reset_enter", 1, 0, 0, 0, 0, 0, 0);

        idle(2);
        done = 1'b1;
        vectors++;
        if (com_q.size() != 0) begin
            miscompares++;
            $display("FAIL commit_missing: got %0d pending commits, expected 0", com_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
